path_arbiter: RTL and testbench

- Round-robin arbiter sharing one downstream output channel between NUM_PATHS path instances.
- Each path raises req; the arbiter returns a one-hot gnt in the same cycle, because a path's bypass logic consumes gnt combinationally.
- Granted data is captured into a registered output stage toward the consumer.
- A burst limit lets one path hold the channel for up to MAX_BURST consecutive beats before priority rotates.

---
 rtl/path_pkg.sv | 14 +
 rtl/path_arbiter_if.sv | 32 +++
 rtl/path_arbiter_rr_pick.sv | 37 +++
 rtl/path_arbiter.sv | 108 ++++++++++
 tb/tb_path_arbiter.sv | 122 ++++++++++++
 5 files changed

// File: rtl/path_pkg.sv
// Shared definitions for the path arbiter slice: arbiter state encoding and
// a width helper that never returns zero.
package path_pkg;

  typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_e;

  // Bits needed to index n items, at least 1 so single-entry vectors stay legal.
  function automatic int clog2_safe(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/path_arbiter_if.sv
// Bundle between the path instances / consumer and the path arbiter.
// With ARB_STATS_EN defined the bundle also carries the grant counters.
interface path_arbiter_if
  import path_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int NUM_PATHS = 4
);
  localparam int OW = clog2_safe(NUM_PATHS);

  logic [NUM_PATHS-1:0]        req_i;
  logic [NUM_PATHS*DWIDTH-1:0] data_i;
  logic                        out_ready_i;
  logic [NUM_PATHS-1:0]        gnt_o;
  logic [DWIDTH-1:0]           data_o;
  logic                        valid_o;
  logic [OW-1:0]               owner_o;
`ifdef ARB_STATS_EN
  logic                        stats_clr_i;
  logic [NUM_PATHS*16-1:0]     stats_o;

  modport master (output req_i, data_i, out_ready_i, stats_clr_i,
                  input  gnt_o, data_o, valid_o, owner_o, stats_o);
  modport slave  (input  req_i, data_i, out_ready_i, stats_clr_i,
                  output gnt_o, data_o, valid_o, owner_o, stats_o);
`else
  modport master (output req_i, data_i, out_ready_i,
                  input  gnt_o, data_o, valid_o, owner_o);
  modport slave  (input  req_i, data_i, out_ready_i,
                  output gnt_o, data_o, valid_o, owner_o);
`endif
endinterface

// File: rtl/path_arbiter_rr_pick.sv
// Combinational round-robin find-first: returns the first set bit of req
// scanning start, start+1, ... with wrap, as one-hot plus index.
module rr_pick
  import path_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2_safe(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Walk N positions from start; explicit wrap keeps non-power-of-two N correct.
  always_comb begin
    int            c;
    logic [IW-1:0] ci;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    ci    = '0;
    for (int i = 0; i < N; i++) begin
      c = int'(start) + i;
      if (c >= N) c = c - N;
      ci = IW'(c);
      if (!found && req[ci]) begin
        found   = 1'b1;
        idx     = ci;
        gnt[ci] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/path_arbiter.sv
// Round-robin arbiter sharing one registered output channel among NUM_PATHS
// paths, with a burst limit of MAX_BURST beats before priority rotates.
// Grant is combinational; data/valid/owner are registered.
// Optional ARB_STATS_EN: per-path 16-bit saturating grant counters.
module path_arbiter
  import path_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int NUM_PATHS = 4,
  parameter int MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  path_arbiter_if.slave  bus
);

  localparam int OW = clog2_safe(NUM_PATHS);
  localparam int BW = clog2_safe(MAX_BURST);
  localparam logic [BW-1:0] BLAST = BW'(MAX_BURST - 1);
  localparam logic [OW-1:0] OLAST = OW'(NUM_PATHS - 1);

  arb_state_e           state_q, state_d;
  logic [OW-1:0]        owner_q, owner_d, start, sel, pick_idx;
  logic [BW-1:0]        cnt_q, cnt_d;
  logic [NUM_PATHS-1:0] own_oh, pick_oh, gnt;
  logic                 pick_any, hold_ok, others, cont, rewrap, take;
  logic [DWIDTH-1:0]    data_q;
  logic                 valid_q;

  assign own_oh  = NUM_PATHS'(1) << owner_q;
  assign hold_ok = (state_q == ARB_HOLD) && bus.req_i[owner_q];
  assign others  = |(bus.req_i & ~own_oh);
  assign cont    = hold_ok && (cnt_q < BLAST);
  assign rewrap  = hold_ok && (cnt_q == BLAST) && !others;
  // Search begins just past the owner so the owner is considered last.
  assign start   = (owner_q == OLAST) ? '0 : owner_q + 1'b1;

  rr_pick #(.N(NUM_PATHS), .IW(OW)) u_pick (
    .req   (bus.req_i),
    .start (start),
    .gnt   (pick_oh),
    .idx   (pick_idx),
    .found (pick_any)
  );

  // Grant decision and next state; a stalled consumer freezes everything.
  always_comb begin
    gnt     = '0;
    take    = 1'b0;
    sel     = owner_q;
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (bus.out_ready_i) begin
      if (cont || rewrap) begin
        take = 1'b1;
      end else if (pick_any) begin
        take = 1'b1;
        sel  = pick_idx;
      end
      if (take) begin
        gnt     = NUM_PATHS'(1) << sel;
        owner_d = sel;
        state_d = ARB_HOLD;
        cnt_d   = cont ? cnt_q + 1'b1 : '0;
      end else begin
        state_d = ARB_IDLE;
        cnt_d   = '0;
      end
    end
  end

  // State, owner, burst count and registered output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      valid_q <= take;
      if (take) data_q <= bus.data_i[int'(sel)*DWIDTH +: DWIDTH];
    end
  end

  assign bus.gnt_o   = gnt;
  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.owner_o = owner_q;

`ifdef ARB_STATS_EN
  for (genvar k = 0; k < NUM_PATHS; k++) begin : g_stat
    logic [15:0] gcnt;
    // Saturating grant counter; clear wins over increment.
    always_ff @(posedge clk) begin
      if (!rst_n)                             gcnt <= '0;
      else if (bus.stats_clr_i)               gcnt <= '0;
      else if (gnt[k] && (gcnt != 16'hFFFF))  gcnt <= gcnt + 16'd1;
    end
    assign bus.stats_o[k*16 +: 16] = gcnt;
  end
`endif

endmodule

// File: tb/tb_path_arbiter.sv
// Directed bench for path_arbiter (NUM_PATHS=4, MAX_BURST=4, DWIDTH=8).
// Path k always drives data 8'hA0+k, so the expected captured beat follows
// from the expected grant alone.
module tb_path_arbiter;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic [1:0] m_owner;
  logic [7:0] m_data;
  logic       m_valid;

  path_arbiter_if #(.DWIDTH(8), .NUM_PATHS(4)) bus ();

  path_arbiter #(.DWIDTH(8), .NUM_PATHS(4), .MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One cycle starting at a negedge: drive, check grant, clock, check outputs.
  task automatic step(input string tag, input logic [3:0] req, input logic rdy,
                      input logic [3:0] eg);
    bus.req_i       = req;
    bus.out_ready_i = rdy;
    #1;
    chk({tag, ":gnt"}, 32'(bus.gnt_o), 32'(eg));
    m_valid = (eg != 4'b0);
    for (int k = 0; k < 4; k++)
      if (eg[k]) begin
        m_owner = 2'(k);
        m_data  = 8'hA0 + 8'(k);
      end
    @(posedge clk); #1;
    chk({tag, ":valid"}, 32'(bus.valid_o), 32'(m_valid));
    chk({tag, ":data"},  32'(bus.data_o),  32'(m_data));
    chk({tag, ":owner"}, 32'(bus.owner_o), 32'(m_owner));
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] eg;
    rst_n           = 1'b0;
    bus.req_i       = '0;
    bus.out_ready_i = 1'b1;
    bus.data_i      = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
`ifdef ARB_STATS_EN
    bus.stats_clr_i = 1'b0;
`endif
    m_owner = '0; m_data = '0; m_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst:valid", 32'(bus.valid_o), 32'd0);
    chk("rst:data",  32'(bus.data_o),  32'd0);
    chk("rst:owner", 32'(bus.owner_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // No requests: nothing granted, owner stays 0.
    repeat (5) step("idle", 4'b0000, 1'b1, 4'b0000);

    // All request: bursts of 4 rotating 1,2,3,0,1.
    for (int g = 0; g < 17; g++) begin
      eg = 4'b0001 << ((1 + g / 4) % 4);
      step("rr_all", 4'b1111, 1'b1, eg);
    end

    // Only path 2: continuous grants, burst count wraps 0,1,2,3,0,1,2,3,0,1.
    repeat (10) step("solo2", 4'b0100, 1'b1, 4'b0100);

    // Path 2 keeps 2 more beats (count 2,3) despite path 0, then drops.
    repeat (2) step("p2_cont", 4'b0101, 1'b1, 4'b0100);
    step("p2_drop", 4'b0001, 1'b1, 4'b0001);
    // Path 0 started fresh: three more beats before rotating to path 1.
    repeat (3) step("p0_burst", 4'b1111, 1'b1, 4'b0001);
    step("p0_rot", 4'b1111, 1'b1, 4'b0010);

    // Path 1 at count 1, then consumer stalls 3 cycles; count must survive.
    step("p1_b1", 4'b1111, 1'b1, 4'b0010);
    repeat (3) step("stall", 4'b1111, 1'b0, 4'b0000);
    repeat (2) step("p1_resume", 4'b1111, 1'b1, 4'b0010);
    step("p1_rot", 4'b1111, 1'b1, 4'b0100);

    // Move ownership to path 3 and reset mid-burst.
    repeat (3) step("p2_burst", 4'b1111, 1'b1, 4'b0100);
    repeat (2) step("p3_burst", 4'b1111, 1'b1, 4'b1000);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst:valid", 32'(bus.valid_o), 32'd0);
    chk("midrst:owner", 32'(bus.owner_o), 32'd0);
    chk("midrst:data",  32'(bus.data_o),  32'd0);
    m_owner = '0; m_data = '0; m_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // Scan from path 1 finds path 3 before path 0.
    step("post_rst", 4'b1001, 1'b1, 4'b1000);
    step("tail", 4'b0000, 1'b1, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
